order_msg_parser: RTL
=====================

// Module: order_msg_parser
// PURPOSE
//  Parses the 32-bit application byte-stream leaving the TCP layer (AXI-Stream, framed by tlast)
//  into fixed order records for the order matching engine. Sits between tcp_layer app_rx and
//  order_matching_engine order input. Validates type/length, drops malformed messages, counts events.
// PARAMETERS
//  CNT_W     16    width of saturating statistics counters
//  TYPE_NEW  8'h4E message type code for new order ('N'), 4 words
//  TYPE_CXL  8'h58 message type code for cancel ('X'), 2 words
// PORTS
//  clk            in   1      single clock, all logic rising-edge
//  rst            in   1      asynchronous, active-high reset
//  s_axis_tdata   in   32     stream word from TCP layer
//  s_axis_tvalid  in   1      stream word valid
//  s_axis_tready  out  1      parser accepts word
//  s_axis_tlast   in   1      last word of message
//  m_ord_valid    out  1      order record valid
//  m_ord_ready    in   1      matching engine accepts record
//  m_ord_type     out  1      0 = new, 1 = cancel
//  m_ord_id       out  32     order id
//  m_ord_price    out  32     price (0 for cancel)
//  m_ord_qty      out  24     quantity (0 for cancel)
//  m_ord_side     out  1      1 = sell, 0 = buy (0 for cancel)
//  msg_count      out  CNT_W  records handed off (m_ord_valid & m_ord_ready)
//  err_count      out  CNT_W  malformed messages dropped
//  seq_gap_count  out  CNT_W  sequence gaps (see CONFIGURATION)
// BEHAVIOUR
//  Word layout: w0 {type[31:24], len[23:16], seq[15:0]}; w1 order_id; NEW only: w2 price;
//   w3 {side[31], rsvd[30:24], qty[23:0]}. len counts words incl. header.
//  Reset: state HDR, all outputs and counters 0, s_axis_tready 0 during reset, 1 first cycle after.
//  Reset mid-message discards partial record; next accepted word is treated as a header.
//  FSM HDR -> BODY -> EMIT -> HDR; any error -> DROP (or HDR if error word has tlast).
//  s_axis_tready = 1 in HDR, BODY, DROP; 0 in EMIT. Transfers only on tvalid & tready.
//  HDR: known type with matching len (N/4, X/2) and tlast=0 -> BODY, word index=1.
//   Unknown type, len mismatch, or tlast=1 on header -> err_count+1; tlast ? HDR : DROP.
//  BODY: capture fields by word index. tlast before final word -> err_count+1, HDR.
//   Final word with tlast -> EMIT. Final word without tlast -> err_count+1, DROP.
//  DROP: consume words, no record; tlast -> HDR.
//  EMIT: m_ord_valid=1, fields held stable until m_ord_ready; on handshake msg_count+1, -> HDR.
//  Latency: m_ord_valid rises the cycle after the final word is accepted; min 1 idle input
//   cycle between messages (EMIT), so peak rate = 1 message per len+1 cycles.
//  m_ord_valid never deasserts without handshake; m_ord_valid=0 outside EMIT.
//  Counters saturate at all-ones (no wrap). Simultaneous events in one cycle cannot occur
//   (one word per cycle, one counter event per word/handshake).
// CONFIGURATION
//  ORDER_PARSER_SEQ_CHECK_EN defined: 16-bit expected-seq register. First record after
//   reset only loads it. On each EMIT handshake, seq != expected -> seq_gap_count+1 (record
//   still delivered); expected <= seq+1 mod 2^16 (0xFFFF -> 0x0000 not a gap). Dropped msgs ignored.
//  Not defined: no seq logic; seq_gap_count tied to 0; header seq field ignored.
// TESTING
//  NEW {4E,04,0001},id=0x1234,price=1000,{1,qty=50} tlast on w3 -> next cycle valid, type0 id 0x1234
//   price 1000 qty 50 side1; msg_count=1.
//  CXL {58,02,0002},id=0x1234, m_ord_ready=0 for 5 cycles -> record held stable, s_axis_tready=0,
//   handshake on ready -> msg_count=2, tready=1 next cycle.
//  Header type 0x41 len 3 + 2 words -> no record, err_count=1, following valid NEW parsed normally.
//  NEW with tlast on w2 -> err_count+1, HDR; NEW with 5 words (no tlast on w3) -> err+1, DROP to tlast.
//  SEQ_CHECK_EN: seqs 10,11,13,14 -> seq_gap_count=1; seq 0xFFFF then 0x0000 -> no gap.
//  rst pulse during w2 of NEW -> outputs/counters 0, no record; next NEW parsed correctly.

Source files
------------

// File: rtl/order_msg_parser_if.sv
// order_msg_parser_if
//   Bundles the two handshake buses of the order message parser.
//   Stream side (TCP layer -> parser):
//     s_axis_tdata[31:0], s_axis_tvalid, s_axis_tlast  driven by the master
//     s_axis_tready                                    driven by the slave
//   Record side (parser -> matching engine):
//     m_ord_valid, m_ord_type, m_ord_id[31:0], m_ord_price[31:0],
//     m_ord_qty[23:0], m_ord_side                      driven by the slave
//     m_ord_ready                                      driven by the master
//   The master modport is the environment around the parser; the slave
//   modport is the parser itself.
interface order_msg_parser_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        m_ord_valid;
    logic        m_ord_ready;
    logic        m_ord_type;
    logic [31:0] m_ord_id;
    logic [31:0] m_ord_price;
    logic [23:0] m_ord_qty;
    logic        m_ord_side;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_ord_ready,
        input  s_axis_tready, m_ord_valid, m_ord_type, m_ord_id,
               m_ord_price, m_ord_qty, m_ord_side
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_ord_ready,
        output s_axis_tready, m_ord_valid, m_ord_type, m_ord_id,
               m_ord_price, m_ord_qty, m_ord_side
    );
endinterface

// File: rtl/order_msg_parser.sv
// order_msg_parser
//   Parses the tlast-framed 32-bit application stream from the TCP layer into
//   fixed order records for the matching engine. Validates message type and
//   length, drops malformed messages and keeps saturating event counters.
//   Word layout: w0 {type, len, seq}; w1 order_id; NEW only: w2 price,
//   w3 {side, rsvd, qty}. len counts words including the header.
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   bus            order_msg_parser_if.slave (s_axis_* stream in, m_ord_* record out)
//   msg_count      records handed off (m_ord_valid & m_ord_ready)
//   err_count      malformed messages dropped
//   seq_gap_count  header sequence gaps seen on delivered records
// Configuration:
//   ORDER_PARSER_SEQ_CHECK_EN  when defined, tracks the expected header
//   sequence number and counts gaps; otherwise seq_gap_count is tied to 0.
module order_msg_parser #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [7:0]  TYPE_NEW = 8'h4E,
    parameter logic [7:0]  TYPE_CXL = 8'h58
) (
    input  logic              clk,
    input  logic              rst,
    order_msg_parser_if.slave bus,
    output logic [CNT_W-1:0]  msg_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  seq_gap_count
);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_BODY,
        ST_EMIT,
        ST_DROP
    } state_t;

    state_t             r_state;
    logic [1:0]         r_idx;
    logic [1:0]         r_last_idx;
    logic               r_valid;
    logic               r_type;
    logic [31:0]        r_id;
    logic [31:0]        r_price;
    logic [23:0]        r_qty;
    logic               r_side;
    logic [CNT_W-1:0]   r_msg_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_xfer;
    logic               w_handshake;
    logic               w_is_new;
    logic               w_is_cxl;
    logic               w_hdr_ok;
    logic               w_final;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Ready is decoded from state so the first cycle after reset already accepts.
    assign bus.s_axis_tready = ~rst & (r_state != ST_EMIT);

    assign w_xfer      = bus.s_axis_tvalid & bus.s_axis_tready;
    assign w_handshake = r_valid & bus.m_ord_ready;
    assign w_is_new    = (bus.s_axis_tdata[31:24] == TYPE_NEW) &&
                         (bus.s_axis_tdata[23:16] == 8'd4);
    assign w_is_cxl    = (bus.s_axis_tdata[31:24] == TYPE_CXL) &&
                         (bus.s_axis_tdata[23:16] == 8'd2);
    assign w_hdr_ok    = (w_is_new | w_is_cxl) & ~bus.s_axis_tlast;
    assign w_final     = (r_idx == r_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HDR;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_valid    <= 1'b0;
            r_type     <= 1'b0;
            r_id       <= '0;
            r_price    <= '0;
            r_qty      <= '0;
            r_side     <= 1'b0;
            r_msg_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_xfer) begin
                        if (w_hdr_ok) begin
                            r_state    <= ST_BODY;
                            r_idx      <= 2'd1;
                            r_last_idx <= w_is_new ? 2'd3 : 2'd1;
                            r_type     <= w_is_cxl;
                            // Cancel records carry zero price/qty/side.
                            r_price    <= '0;
                            r_qty      <= '0;
                            r_side     <= 1'b0;
                        end else begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                            r_state   <= bus.s_axis_tlast ? ST_HDR : ST_DROP;
                        end
                    end
                end
                ST_BODY: begin
                    if (w_xfer) begin
                        case (r_idx)
                            2'd1: r_id <= bus.s_axis_tdata;
                            2'd2: r_price <= bus.s_axis_tdata;
                            2'd3: begin
                                r_side <= bus.s_axis_tdata[31];
                                r_qty  <= bus.s_axis_tdata[23:0];
                            end
                            default: ;
                        endcase
                        if (w_final) begin
                            if (bus.s_axis_tlast) begin
                                r_valid <= 1'b1;
                                r_state <= ST_EMIT;
                            end else begin
                                r_err_cnt <= sat_inc(r_err_cnt);
                                r_state   <= ST_DROP;
                            end
                        end else if (bus.s_axis_tlast) begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                            r_state   <= ST_HDR;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        r_valid   <= 1'b0;
                        r_msg_cnt <= sat_inc(r_msg_cnt);
                        r_state   <= ST_HDR;
                    end
                end
                ST_DROP: begin
                    if (w_xfer && bus.s_axis_tlast) begin
                        r_state <= ST_HDR;
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    assign bus.m_ord_valid = r_valid;
    assign bus.m_ord_type  = r_type;
    assign bus.m_ord_id    = r_id;
    assign bus.m_ord_price = r_price;
    assign bus.m_ord_qty   = r_qty;
    assign bus.m_ord_side  = r_side;
    assign msg_count       = r_msg_cnt;
    assign err_count       = r_err_cnt;

`ifdef ORDER_PARSER_SEQ_CHECK_EN
    logic [15:0]      r_seq;
    logic [15:0]      r_exp_seq;
    logic             r_seq_init;
    logic [CNT_W-1:0] r_gap_cnt;

    // Only messages that reach the record output take part; dropped ones never
    // update the expected sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq      <= '0;
            r_exp_seq  <= '0;
            r_seq_init <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            if ((r_state == ST_HDR) && w_xfer && w_hdr_ok) begin
                r_seq <= bus.s_axis_tdata[15:0];
            end
            if (w_handshake) begin
                r_seq_init <= 1'b1;
                if (r_seq_init && (r_seq != r_exp_seq)) begin
                    r_gap_cnt <= sat_inc(r_gap_cnt);
                end
                r_exp_seq <= r_seq + 16'd1;
            end
        end
    end

    assign seq_gap_count = r_gap_cnt;
`else
    assign seq_gap_count = '0;
`endif

endmodule
